// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state, master-to-slave
// request bundle and slave-to-master response bundle.
package wb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic             cyc;
        logic             stb;
    } wb_m2s_t;

    typedef struct packed {
        logic [DAT_W-1:0] dat;
        logic             ack;
        logic             err;
    } wb_s2m_t;

    // Watchdog counter width; never narrower than one bit, even with the watchdog off.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_arb_if.sv
// One Wishbone classic link: request bundle toward the slave side, response
// bundle back toward the master side.
interface wb_arb_if;
    import wb_arb_pkg::*;

    wb_m2s_t m2s;
    wb_s2m_t s2m;

    modport master (output m2s, input s2m);
    modport slave  (input m2s, output s2m);

endinterface

// File: rtl/wb_arb_timer.sv
// Saturating bus-timeout counter: counts silent strobe cycles and flags the
// cycle in which the count reaches TIMEOUT-1 while the slave is still silent.
module wb_arb_timer
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int            CW      = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic          WD_ON   = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || !en) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // en already excludes ack/err, so a terminating slave always beats the abort.
    assign expire = WD_ON && en && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 classic arbiter: round-robin per tenure, grant held
// until the owner drops cyc, stalled slaves aborted by a watchdog.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    wb_arb_if.slave    m0,
    wb_arb_if.slave    m1,
    wb_arb_if.master   s,
    output logic [1:0] grant_o
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       expire;
    logic       wd_en;
    logic       wd_clr;
    wb_m2s_t    own_req;

    assign own_req = owner_q ? m1.m2s : m0.m2s;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.m2s.cyc || m1.m2s.cyc) begin
                    state_d = OWN;
                    // Under contention the master that did not hold the last tenure wins.
                    owner_d = (m0.m2s.cyc && m1.m2s.cyc) ? ~last_q : m1.m2s.cyc;
                    last_d  = owner_d;
                end
            end
            OWN: begin
                if (!own_req.cyc) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!own_req.cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wd_en  = (state_q == OWN) && own_req.stb && !s.s2m.ack && !s.s2m.err;
    assign wd_clr = (state_d != state_q);

    wb_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (expire)
    );

    // Read data is broadcast; only terminations are steered by ownership.
    always_comb begin
        s.m2s   = '0;
        m0.s2m  = '{dat: s.s2m.dat, ack: 1'b0, err: 1'b0};
        m1.s2m  = '{dat: s.s2m.dat, ack: 1'b0, err: 1'b0};
        grant_o = 2'b00;
        case (state_q)
            OWN: begin
                s.m2s   = own_req;
                grant_o = owner_onehot(owner_q);
                if (owner_q) begin
                    m1.s2m.ack = s.s2m.ack;
                    m1.s2m.err = s.s2m.err | expire;
                end else begin
                    m0.s2m.ack = s.s2m.ack;
                    m0.s2m.err = s.s2m.err | expire;
                end
            end
            ABORT: begin
                grant_o = owner_onehot(owner_q);
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2 (TIMEOUT=4): scenario tasks with a response scoreboard.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  grant;
    int          n_total = 0;
    int          n_pass  = 0;

    typedef struct {
        int          m;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [33:0] obs;

    wb_arb_if m0_if();
    wb_arb_if m1_if();
    wb_arb_if s_if();

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_timeout simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_if.m2s = '0;
        m1_if.m2s = '0;
        s_if.s2m  = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        s_if.s2m.dat = 32'h1234_5678;
        m0_if.m2s.cyc = 1'b1;
        m0_if.m2s.stb = 1'b1;
        m0_if.m2s.adr = 32'hFFFF_0000;
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL rst_grant got %b expected 00", grant); else n_pass++;
        n_total++; if ({s_if.m2s.cyc, s_if.m2s.stb, s_if.m2s.we} !== 3'b000) $display("FAIL rst_sctl got %b expected 000", {s_if.m2s.cyc, s_if.m2s.stb, s_if.m2s.we}); else n_pass++;
        n_total++; if (s_if.m2s.adr !== 32'h0) $display("FAIL rst_sadr got %h expected 0", s_if.m2s.adr); else n_pass++;
        n_total++; if ({m0_if.s2m.ack, m0_if.s2m.err, m1_if.s2m.ack, m1_if.s2m.err} !== 4'b0) $display("FAIL rst_term got %b expected 0000", {m0_if.s2m.ack, m0_if.s2m.err, m1_if.s2m.ack, m1_if.s2m.err}); else n_pass++;
        n_total++; if ({m0_if.s2m.dat, m1_if.s2m.dat} !== {32'h1234_5678, 32'h1234_5678}) $display("FAIL rst_dat got %h %h expected 12345678", m0_if.s2m.dat, m1_if.s2m.dat); else n_pass++;
        tick();
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        m0_if.m2s = '{adr: 32'h0000_0010, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        sb.push_back('{m: 0, err: 1'b0, dat: 32'hDEAD_BEEF});
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL sr_latency got %b expected 00", grant); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (grant !== 2'b01) $display("FAIL sr_grant got %b expected 01", grant); else n_pass++;
        n_total++; if ({s_if.m2s.cyc, s_if.m2s.stb, s_if.m2s.adr} !== {2'b11, 32'h10}) $display("FAIL sr_bus got cyc/stb=%b adr=%h expected 11 00000010", {s_if.m2s.cyc, s_if.m2s.stb}, s_if.m2s.adr); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (m0_if.s2m.ack !== 1'b0) $display("FAIL sr_wait got ack=%b expected 0", m0_if.s2m.ack); else n_pass++;
        tick();
        s_if.s2m = '{dat: 32'hDEAD_BEEF, ack: 1'b1, err: 1'b0};
        @(negedge clk);
        n_total++;
        if (sb.size() == 0) $display("FAIL sr_resp got empty queue expected entry");
        else begin
            e = sb.pop_front();
            obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
            if (obs !== {~e.err, e.err, e.dat}) $display("FAIL sr_resp got %h expected %h", obs, {~e.err, e.err, e.dat}); else n_pass++;
        end
        n_total++; if ({m1_if.s2m.ack, m1_if.s2m.err} !== 2'b00) $display("FAIL sr_m1_quiet got %b expected 00", {m1_if.s2m.ack, m1_if.s2m.err}); else n_pass++;
        n_total++; if (m1_if.s2m.dat !== 32'hDEAD_BEEF) $display("FAIL sr_bcast got %h expected deadbeef", m1_if.s2m.dat); else n_pass++;
        tick();
        m0_if.m2s.cyc = 1'b0;
        m0_if.m2s.stb = 1'b0;
        s_if.s2m.ack  = 1'b0;
        @(negedge clk);
        n_total++; if (s_if.m2s.cyc !== 1'b0) $display("FAIL sr_release got cyc=%b expected 0", s_if.m2s.cyc); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL sr_idle got %b expected 00", grant); else n_pass++;
    endtask

    task automatic test_contention();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m0_if.m2s = '{adr: 32'h0000_0100, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        m1_if.m2s = '{adr: 32'h0000_0200, dat: 32'hCAFE_0001, sel: 4'h3, we: 1'b1, cyc: 1'b1, stb: 1'b1};
        sb.push_back('{m: 0, err: 1'b0, dat: 32'h1111_0000});
        sb.push_back('{m: 1, err: 1'b0, dat: 32'h2222_0000});
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL ct_latency got %b expected 00", grant); else n_pass++;
        tick();
        s_if.s2m = '{dat: 32'h1111_0000, ack: 1'b1, err: 1'b0};
        @(negedge clk);
        n_total++; if (grant !== 2'b01) $display("FAIL ct_first got %b expected 01", grant); else n_pass++;
        n_total++; if (s_if.m2s.adr !== 32'h100) $display("FAIL ct_adr0 got %h expected 00000100", s_if.m2s.adr); else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL ct_resp0 got empty queue expected entry");
        else begin
            e = sb.pop_front();
            obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
            if (obs !== {~e.err, e.err, e.dat}) $display("FAIL ct_resp0 got %h expected %h", obs, {~e.err, e.err, e.dat}); else n_pass++;
        end
        n_total++; if (m1_if.s2m.ack !== 1'b0) $display("FAIL ct_m1_noack got %b expected 0", m1_if.s2m.ack); else n_pass++;
        tick();
        m0_if.m2s.cyc = 1'b0;
        m0_if.m2s.stb = 1'b0;
        s_if.s2m.ack  = 1'b0;
        @(negedge clk);
        n_total++; if (s_if.m2s.cyc !== 1'b0) $display("FAIL ct_release got cyc=%b expected 0", s_if.m2s.cyc); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL ct_dead got %b expected 00", grant); else n_pass++;
        tick();
        s_if.s2m = '{dat: 32'h2222_0000, ack: 1'b1, err: 1'b0};
        @(negedge clk);
        n_total++; if (grant !== 2'b10) $display("FAIL ct_second got %b expected 10", grant); else n_pass++;
        n_total++; if ({s_if.m2s.adr, s_if.m2s.dat, s_if.m2s.sel, s_if.m2s.we} !== {32'h200, 32'hCAFE_0001, 4'h3, 1'b1}) $display("FAIL ct_m1_bus got adr=%h dat=%h sel=%h we=%b expected 00000200 cafe0001 3 1", s_if.m2s.adr, s_if.m2s.dat, s_if.m2s.sel, s_if.m2s.we); else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL ct_resp1 got empty queue expected entry");
        else begin
            e = sb.pop_front();
            obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
            if (obs !== {~e.err, e.err, e.dat}) $display("FAIL ct_resp1 got %h expected %h", obs, {~e.err, e.err, e.dat}); else n_pass++;
        end
        n_total++; if (m0_if.s2m.ack !== 1'b0) $display("FAIL ct_m0_noack got %b expected 0", m0_if.s2m.ack); else n_pass++;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        int         own;
        tick();
        m0_if.m2s = '{adr: 32'h0000_0300, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        m1_if.m2s = '{adr: 32'h0000_0400, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        for (int k = 0; k < 4; k++) begin
            own   = k % 2;
            exp_g = (own == 1) ? 2'b10 : 2'b01;
            sb.push_back('{m: own, err: 1'b0, dat: 32'hA000_0000 + k});
            tick();
            s_if.s2m = '{dat: 32'hA000_0000 + k, ack: 1'b1, err: 1'b0};
            @(negedge clk);
            n_total++; if (grant !== exp_g) $display("FAIL rr_grant%0d got %b expected %b", k, grant, exp_g); else n_pass++;
            n_total++;
            if (sb.size() == 0) $display("FAIL rr_resp%0d got empty queue expected entry", k);
            else begin
                e = sb.pop_front();
                obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
                if (obs !== {~e.err, e.err, e.dat}) $display("FAIL rr_resp%0d got %h expected %h", k, obs, {~e.err, e.err, e.dat}); else n_pass++;
            end
            n_total++; if (((own == 1) ? m0_if.s2m.ack : m1_if.s2m.ack) !== 1'b0) $display("FAIL rr_other%0d got ack=1 expected 0", k); else n_pass++;
            tick();
            s_if.s2m.ack = 1'b0;
            if (own == 1) begin m1_if.m2s.cyc = 1'b0; m1_if.m2s.stb = 1'b0; end
            else begin m0_if.m2s.cyc = 1'b0; m0_if.m2s.stb = 1'b0; end
            @(negedge clk);
            n_total++; if (s_if.m2s.cyc !== 1'b0) $display("FAIL rr_release%0d got cyc=%b expected 0", k, s_if.m2s.cyc); else n_pass++;
            tick();
            if (own == 1) begin m1_if.m2s.cyc = 1'b1; m1_if.m2s.stb = 1'b1; end
            else begin m0_if.m2s.cyc = 1'b1; m0_if.m2s.stb = 1'b1; end
            @(negedge clk);
            n_total++; if (grant !== 2'b00) $display("FAIL rr_dead%0d got %b expected 00", k, grant); else n_pass++;
        end
        tick();
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        tick();
        m1_if.m2s = '{adr: 32'h0000_0500, dat: 32'h0BAD_F00D, sel: 4'hF, we: 1'b1, cyc: 1'b1, stb: 1'b1};
        s_if.s2m.dat = 32'h0000_0000;
        sb.push_back('{m: 1, err: 1'b1, dat: 32'h0000_0000});
        tick();
        @(negedge clk);
        n_total++; if ({grant, s_if.m2s.cyc} !== 3'b101) $display("FAIL to_grant got grant=%b cyc=%b expected 10 1", grant, s_if.m2s.cyc); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            n_total++; if (m1_if.s2m.err !== 1'b0) $display("FAIL to_early%0d got err=%b expected 0", c, m1_if.s2m.err); else n_pass++;
        end
        tick();
        @(negedge clk);
        n_total++;
        if (sb.size() == 0) $display("FAIL to_resp got empty queue expected entry");
        else begin
            e = sb.pop_front();
            obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
            if (obs !== {~e.err, e.err, e.dat}) $display("FAIL to_resp got %h expected %h", obs, {~e.err, e.err, e.dat}); else n_pass++;
        end
        n_total++; if (m0_if.s2m.err !== 1'b0) $display("FAIL to_m0_quiet got err=%b expected 0", m0_if.s2m.err); else n_pass++;
        tick();
        s_if.s2m.ack = 1'b1;
        @(negedge clk);
        n_total++; if ({s_if.m2s.cyc, s_if.m2s.stb} !== 2'b00) $display("FAIL to_abort_bus got %b expected 00", {s_if.m2s.cyc, s_if.m2s.stb}); else n_pass++;
        n_total++; if ({m1_if.s2m.ack, m1_if.s2m.err} !== 2'b00) $display("FAIL to_late_ack got %b expected 00", {m1_if.s2m.ack, m1_if.s2m.err}); else n_pass++;
        tick();
        s_if.s2m.ack = 1'b0;
        m1_if.m2s.cyc = 1'b0;
        m1_if.m2s.stb = 1'b0;
        tick();
        @(negedge clk);
        n_total++; if (grant !== 2'b00) $display("FAIL to_idle got %b expected 00", grant); else n_pass++;
    endtask

    task automatic test_ack_at_timeout();
        tick();
        m0_if.m2s = '{adr: 32'h0000_0600, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        sb.push_back('{m: 0, err: 1'b0, dat: 32'h5A5A_5A5A});
        tick();
        tick();
        tick();
        @(negedge clk);
        n_total++; if ({m0_if.s2m.ack, m0_if.s2m.err} !== 2'b00) $display("FAIL at_wait got %b expected 00", {m0_if.s2m.ack, m0_if.s2m.err}); else n_pass++;
        tick();
        s_if.s2m = '{dat: 32'h5A5A_5A5A, ack: 1'b1, err: 1'b0};
        @(negedge clk);
        n_total++;
        if (sb.size() == 0) $display("FAIL at_resp got empty queue expected entry");
        else begin
            e = sb.pop_front();
            obs = (e.m == 1) ? {m1_if.s2m.ack, m1_if.s2m.err, m1_if.s2m.dat} : {m0_if.s2m.ack, m0_if.s2m.err, m0_if.s2m.dat};
            if (obs !== {~e.err, e.err, e.dat}) $display("FAIL at_resp got %h expected %h", obs, {~e.err, e.err, e.dat}); else n_pass++;
        end
        tick();
        s_if.s2m.ack = 1'b0;
        m0_if.m2s.stb = 1'b0;
        @(negedge clk);
        n_total++; if ({grant, s_if.m2s.cyc} !== 3'b011) $display("FAIL at_still_own got grant=%b cyc=%b expected 01 1", grant, s_if.m2s.cyc); else n_pass++;
        tick();
        m0_if.m2s.cyc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        m1_if.m2s = '{adr: 32'h0000_0700, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        tick();
        @(negedge clk);
        n_total++; if (grant !== 2'b10) $display("FAIL rm_grant got %b expected 10", grant); else n_pass++;
        #2;
        rst = 1'b1;
        s_if.s2m.ack = 1'b1;
        #1;
        n_total++; if ({grant, s_if.m2s.cyc, s_if.m2s.stb} !== 4'b0000) $display("FAIL rm_async got grant=%b cyc/stb=%b expected 00 00", grant, {s_if.m2s.cyc, s_if.m2s.stb}); else n_pass++;
        n_total++; if ({m1_if.s2m.ack, m1_if.s2m.err} !== 2'b00) $display("FAIL rm_noterm got %b expected 00", {m1_if.s2m.ack, m1_if.s2m.err}); else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        s_if.s2m.ack = 1'b0;
        m0_if.m2s = '{adr: 32'h0000_0800, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: 1'b1, stb: 1'b1};
        tick();
        @(negedge clk);
        n_total++; if ({grant, s_if.m2s.adr} !== {2'b01, 32'h800}) $display("FAIL rm_regrant got grant=%b adr=%h expected 01 00000800", grant, s_if.m2s.adr); else n_pass++;
        tick();
        idle_all();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        n_total++; if (sb.size() != 0) $display("FAIL sb_drained got %0d entries expected 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone B4 classic arbiter with bus-timeout watchdog. It shares the single interconnect master port between the processor's Wishbone data master (m0) and a second requester (m1; boot loader or DMA engine). Arbitration is round-robin per bus tenure. The grant is held until the granted master drops `cyc`. A stalled slave is aborted with an error after a programmable number of cycles.

## Interface
- `TIMEOUT`, default 255: wait-state cycles before abort; 0 disables the watchdog.
- `wb_clk_i`  in  1  clock; everything is on the rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `m0_adr_i` / `m1_adr_i`  in  32  master address.
- `m0_dat_i` / `m1_dat_i`  in  32  master write data.
- `m0_sel_i` / `m1_sel_i`  in  4  byte enables.
- `m0_we_i`, `m0_cyc_i`, `m0_stb_i` (same for m1)  in  1  master control.
- `m0_dat_o` / `m1_dat_o`  out  32  read data; `s_dat_i` broadcast to both.
- `m0_ack_o`, `m0_err_o` (same for m1)  out  1  termination, gated by grant.
- `s_adr_o`  out  32, `s_dat_o`  out  32, `s_sel_o`  out  4, `s_we_o`, `s_cyc_o`, `s_stb_o`  out  1  toward the interconnect.
- `s_dat_i`  in  32, `s_ack_i`, `s_err_i`  in  1  from the interconnect.
- `grant_o`  out  2  one-hot current owner; 00 when idle.

## Operation
- States are IDLE, OWN, ABORT. A registered `owner` bit and a registered `last` bit (the last master granted) hold arbitration state.
- IDLE:
  - One master has `cyc_i`=1: grant it, go to OWN.
  - Both masters have `cyc_i`=1: grant the master ≠ `last`, go to OWN.
  - On grant, set `last` to the granted master.
- OWN:
  - Slave outputs are a combinational mux of the owner's inputs. `s_cyc_o`=owner `cyc_i`; `s_stb_o`=owner `stb_i`.
  - Owner `ack_o`=`s_ack_i` and owner `err_o`=`s_err_i`. The non-owner's ack and err are 0.
  - Owner `cyc_i`=0: go to IDLE.
- Watchdog:
  - The counter increments each cycle in OWN with `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0. It clears otherwise, and on every state change.
  - When the count reaches `TIMEOUT`-1 with the slave still silent: owner `err_o`=1 for that cycle, then go to ABORT.
- ABORT:
  - `s_cyc_o`, `s_stb_o` and both masters' ack/err are forced 0. Late slave ack/err is discarded.
  - Owner `cyc_i`=0: go to IDLE.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.
- Outside OWN: `s_cyc_o`=`s_stb_o`=`s_we_o`=0, `s_sel_o`=0, `s_adr_o`=`s_dat_o`=0.

## Timing
- Reset values:
  - State IDLE, `owner`=0, `last`=1 (m0 wins the first contention), counter 0.
  - `grant_o`=00, and all `s_*` control outputs 0.
  - Master ack/err 0; `dat_o` follows `s_dat_i`.
- Grant latency: master `cyc_i` rises in cycle n; `grant_o` and `s_cyc_o` are asserted in cycle n+1.
- Data path in OWN has zero added latency: slave ack in cycle k gives master ack in cycle k.
- Release: owner drops `cyc_i` in cycle r, so `s_cyc_o`=0 in r (combinational). State is IDLE in r+1, and a waiting master is granted in r+2. There is exactly one dead cycle between tenures.
- A master re-raising `cyc_i` in r+1 competes under round-robin. When both are requesting, the other master wins.
- Timeout: `stb` is asserted in cycle s with no ack, so `err_o` pulses in cycle s+`TIMEOUT`-1 and state is ABORT from s+`TIMEOUT`.
- A slave ack arriving in the same cycle the count hits `TIMEOUT`-1 wins: ack is passed, no err.
- Reset asserted mid-tenure forces all outputs to reset values immediately (asynchronously). No termination is sent to the master.

## Structure
- Package `wb_arb_pkg` holds:
  - `arb_state_t` enum (IDLE, OWN, ABORT);
  - `wb_m2s_t` struct (adr, dat, sel, we, cyc, stb);
  - `wb_s2m_t` struct (dat, ack, err).
- One sub-module, `wb_arb_timer`: the saturating watchdog counter. Inputs are enable, clear and `TIMEOUT`; output is `expire`.
- The FSM, grant mux and response demux live in `wb_arbiter2`.

## Test plan
- Single m0 read of 0x0000_0010 (slave acks after 2 waits, data 0xDEADBEEF): `grant_o`=01 one cycle after `cyc`; `m0_ack_o` with `m0_dat_o`=0xDEADBEEF; `m1_ack_o` stays 0.
- m0 and m1 raise `cyc` in the same cycle after reset: m0 granted first. After m0 releases, one dead cycle, then `grant_o`=10 and m1's address appears on `s_adr_o`.
- Both masters request continuously with 1-beat tenures: grants alternate 01,10,01,10. Neither master waits more than one tenure plus one dead cycle.
- `TIMEOUT`=4, slave never acks on an m1 write: `m1_err_o` pulses 3 cycles after `stb`. `s_cyc_o`=0 from the next cycle. A late `s_ack_i` is not forwarded; IDLE follows when m1 drops `cyc`.
- Slave ack coincides with the timeout cycle (`TIMEOUT`=4, ack on the 4th stb cycle): `ack_o`=1, `err_o`=0, state stays OWN.
- `wb_rst_i` pulsed mid-tenure of m1: `grant_o`=00 and `s_cyc_o`=0 immediately. The next contention grants m0.
